usb_tx_line_driver: RTL and testbench

Downstream stage of the handshake/packet bit generators (ACK and siblings). It takes the raw serial bit stream, output-enable and EOP request, all advanced on the bit-rate enable, and produces the USB differential line. NRZI encoding, bit stuffing with upstream stall, EOP (SE0 then J) generation and the transceiver output-enable are handled here. It drives the D+/D- pad buffers directly.

---
 rtl/usb_line_pkg.sv | 39 +++
 rtl/usb_nrzi_stuffer.sv | 60 ++++++
 rtl/usb_tx_line_driver.sv | 164 ++++++++++++++++
 tb/tb_usb_tx_line_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/usb_line_pkg.sv
// Shared types and line codes for the USB transmit line driver.
// USB_TX_STUFF_EN selects whether the bit-stuffing state exists at all.
package usb_line_pkg;

`ifdef USB_TX_STUFF_EN
    localparam bit STUFF_EN = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } tx_state_t;
`else
    localparam bit STUFF_EN = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DATA    = 3'd1,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } tx_state_t;
`endif

    localparam int DEFAULT_STUFF_LIMIT = 6;

    // Line codes are {dPlus, dMinus}
    localparam logic [1:0] LINE_SE0 = 2'b00;

    function automatic logic [1:0] line_j(input bit low_speed);
        return low_speed ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] line_k(input bit low_speed);
        return low_speed ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI level register and consecutive-ones counter with the stuff decision.
// level_next is 1 for J, 0 for K; registers advance only when ce is high.
module usb_nrzi_stuffer
    import usb_line_pkg::*;
#(
    parameter int STUFF_LIMIT = DEFAULT_STUFF_LIMIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       clear,
    input  logic       shift,
    input  logic       data_bit,
    input  logic       stuff,
    output logic       level_next,
    output logic       stuff_req,
    output logic [2:0] ones_count
);

    // Without stuffing the counter is purely informative and saturates at 7
    localparam logic [2:0] COUNT_MAX = STUFF_EN ? 3'(STUFF_LIMIT) : 3'd7;

    logic       level_reg;
    logic [2:0] count_reg;
    logic [2:0] count_next;

    always_comb begin
        level_next = level_reg;
        count_next = count_reg;
        stuff_req  = 1'b0;
        if (clear) begin
            level_next = 1'b1;
            count_next = 3'd0;
        end else if (stuff) begin
            level_next = ~level_reg;
            count_next = 3'd0;
        end else if (shift) begin
            if (!data_bit) begin
                level_next = ~level_reg;
                count_next = 3'd0;
            end else if (count_reg != COUNT_MAX) begin
                count_next = count_reg + 3'd1;
                stuff_req  = STUFF_EN && ((count_reg + 3'd1) == COUNT_MAX);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg <= 1'b1;
            count_reg <= 3'd0;
        end else if (ce) begin
            level_reg <= level_next;
            count_reg <= count_next;
        end
    end

    assign ones_count = count_reg;

endmodule

// File: rtl/usb_tx_line_driver.sv
// USB transmit line driver: EOP state machine and D+/D- pad muxing around the NRZI/stuffer.
// Define USB_TX_STUFF_EN to build in bit stuffing (STUFF state, txReady stall).
module usb_tx_line_driver
    import usb_line_pkg::*;
#(
    parameter bit LOW_SPEED    = 1'b0,
    parameter int EOP_SE0_BITS = 2,
    parameter int STUFF_LIMIT  = DEFAULT_STUFF_LIMIT
) (
    input  logic       useClk,
    input  logic       rstN,
    input  logic       checkData,
    input  logic       txOE,
    input  logic       txBit,
    input  logic       callEop,
    output logic       txReady,
    output logic       dPlus,
    output logic       dMinus,
    output logic       lineOE,
    output logic [2:0] stuffCount
);

    localparam logic [1:0] LINE_J   = line_j(LOW_SPEED);
    localparam logic [1:0] LINE_K   = line_k(LOW_SPEED);
    localparam logic [2:0] SE0_LAST = 3'(EOP_SE0_BITS);

    tx_state_t  state_reg;
    logic [2:0] se0_cnt_reg;
    logic       eop_prev_reg;
    logic [1:0] line_reg;
    logic       line_oe_reg;
    logic       ready_reg;

    logic       eop_rise;
    logic       nrzi_clear;
    logic       nrzi_shift;
    logic       nrzi_stuff;
    logic       level_next;
    logic       stuff_req;
    logic [1:0] line_data;
    tx_state_t  data_state;

    usb_nrzi_stuffer #(
        .STUFF_LIMIT(STUFF_LIMIT)
    ) u_nrzi (
        .clk       (useClk),
        .rst_n     (rstN),
        .ce        (checkData),
        .clear     (nrzi_clear),
        .shift     (nrzi_shift),
        .data_bit  (txBit),
        .stuff     (nrzi_stuff),
        .level_next(level_next),
        .stuff_req (stuff_req),
        .ones_count(stuffCount)
    );

    always_comb begin
        eop_rise   = callEop & ~eop_prev_reg;
        nrzi_clear = 1'b0;
        nrzi_shift = 1'b0;
        nrzi_stuff = 1'b0;
        line_data  = level_next ? LINE_J : LINE_K;
`ifdef USB_TX_STUFF_EN
        data_state = stuff_req ? STUFF : DATA;
`else
        data_state = DATA;
`endif
        case (state_reg)
            IDLE: begin
                if (txOE) nrzi_shift = 1'b1;
                else      nrzi_clear = 1'b1;
            end
            DATA: begin
                if (eop_rise)  nrzi_clear = 1'b1;
                else if (txOE) nrzi_shift = 1'b1;
                else           nrzi_clear = 1'b1;
            end
`ifdef USB_TX_STUFF_EN
            STUFF: begin
                // EOP wins over a pending stuffed bit
                if (eop_rise) nrzi_clear = 1'b1;
                else          nrzi_stuff = 1'b1;
            end
`endif
            default: nrzi_clear = 1'b1;
        endcase
    end

    always_ff @(posedge useClk or negedge rstN) begin
        if (!rstN) begin
            state_reg    <= IDLE;
            se0_cnt_reg  <= 3'd0;
            eop_prev_reg <= 1'b0;
            line_reg     <= LINE_J;
            line_oe_reg  <= 1'b0;
            ready_reg    <= 1'b1;
        end else if (checkData) begin
            eop_prev_reg <= callEop;
            case (state_reg)
                IDLE: begin
                    if (txOE) begin
                        state_reg   <= data_state;
                        line_reg    <= line_data;
                        line_oe_reg <= 1'b1;
                        ready_reg   <= ~stuff_req;
                    end
                end
                DATA: begin
                    if (eop_rise) begin
                        state_reg   <= EOP_SE0;
                        se0_cnt_reg <= 3'd1;
                        line_reg    <= LINE_SE0;
                        line_oe_reg <= 1'b1;
                        ready_reg   <= 1'b1;
                    end else if (txOE) begin
                        state_reg   <= data_state;
                        line_reg    <= line_data;
                        ready_reg   <= ~stuff_req;
                    end else begin
                        state_reg   <= IDLE;
                        line_reg    <= LINE_J;
                        line_oe_reg <= 1'b0;
                        ready_reg   <= 1'b1;
                    end
                end
`ifdef USB_TX_STUFF_EN
                STUFF: begin
                    if (eop_rise) begin
                        state_reg   <= EOP_SE0;
                        se0_cnt_reg <= 3'd1;
                        line_reg    <= LINE_SE0;
                    end else begin
                        state_reg   <= DATA;
                        line_reg    <= line_data;
                    end
                    ready_reg <= 1'b1;
                end
`endif
                EOP_SE0: begin
                    if (se0_cnt_reg == SE0_LAST) begin
                        state_reg <= EOP_J;
                        line_reg  <= LINE_J;
                    end else begin
                        se0_cnt_reg <= se0_cnt_reg + 3'd1;
                    end
                end
                default: begin
                    // EOP_J: release the pads; txOE is not honoured until the next bit
                    state_reg   <= IDLE;
                    line_reg    <= LINE_J;
                    line_oe_reg <= 1'b0;
                    ready_reg   <= 1'b1;
                end
            endcase
        end
    end

    assign dPlus   = line_reg[1];
    assign dMinus  = line_reg[0];
    assign lineOE  = line_oe_reg;
    assign txReady = ready_reg;

endmodule

// File: tb/tb_usb_tx_line_driver.sv
// Directed vector bench for usb_tx_line_driver; a full-speed and a low-speed
// instance share stimulus, low-speed expectations are the J/K-inverted full-speed ones.
module tb_usb_tx_line_driver;

    logic       useClk    = 1'b0;
    logic       rstN      = 1'b0;
    logic       checkData = 1'b0;
    logic       txOE      = 1'b0;
    logic       txBit     = 1'b0;
    logic       callEop   = 1'b0;

    logic       fs_ready, fs_dp, fs_dm, fs_oe;
    logic [2:0] fs_cnt;
    logic       ls_ready, ls_dp, ls_dm, ls_oe;
    logic [2:0] ls_cnt;

`ifdef USB_TX_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] LS = 2'b00;

    usb_tx_line_driver #(.LOW_SPEED(1'b0), .EOP_SE0_BITS(2), .STUFF_LIMIT(6)) dut_fs (
        .useClk(useClk), .rstN(rstN), .checkData(checkData), .txOE(txOE),
        .txBit(txBit), .callEop(callEop), .txReady(fs_ready), .dPlus(fs_dp),
        .dMinus(fs_dm), .lineOE(fs_oe), .stuffCount(fs_cnt)
    );

    usb_tx_line_driver #(.LOW_SPEED(1'b1), .EOP_SE0_BITS(2), .STUFF_LIMIT(6)) dut_ls (
        .useClk(useClk), .rstN(rstN), .checkData(checkData), .txOE(txOE),
        .txBit(txBit), .callEop(callEop), .txReady(ls_ready), .dPlus(ls_dp),
        .dMinus(ls_dm), .lineOE(ls_oe), .stuffCount(ls_cnt)
    );

    always #5 useClk = ~useClk;

    typedef struct {
        logic       oe;
        logic       b;
        logic       eop;
        logic [1:0] line;
        logic       line_oe;
        logic       rdy;
        logic [2:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [1:0] line, input logic oe,
                         input logic rdy, input logic [2:0] cnt);
        logic [6:0] exp_fs, exp_ls, act_fs, act_ls;
        exp_fs = {line, oe, rdy, cnt};
        exp_ls = {(line == LS) ? LS : ~line, oe, rdy, cnt};
        act_fs = {fs_dp, fs_dm, fs_oe, fs_ready, fs_cnt};
        act_ls = {ls_dp, ls_dm, ls_oe, ls_ready, ls_cnt};
        n_vec++;
        if (act_fs !== exp_fs || act_ls !== exp_ls) begin
            n_err++;
            $display("FAIL %s: fs dp,dm,oe,rdy,cnt=%b required %b; ls=%b required %b",
                     name, act_fs, exp_fs, act_ls, exp_ls);
        end else begin
            $display("ok   %s: fs dp,dm,oe,rdy,cnt=%b ls=%b", name, act_fs, act_ls);
        end
    endtask

    // One bit period: an enabled clock followed by a gated clock
    task automatic drive_bit(input logic oe, input logic b, input logic eop);
        txOE      = oe;
        txBit     = b;
        callEop   = eop;
        checkData = 1'b1;
        @(negedge useClk);
        checkData = 1'b0;
        @(negedge useClk);
    endtask

    function automatic void add(input logic oe, input logic b, input logic eop,
                                input logic [1:0] line, input logic loe,
                                input logic rdy, input logic [2:0] cnt);
        vec_t v;
        v.oe = oe; v.b = b; v.eop = eop;
        v.line = line; v.line_oe = loe; v.rdy = rdy; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive_bit(vecs[i].oe, vecs[i].b, vecs[i].eop);
            check($sformatf("%s[%0d]", tag, i), vecs[i].line, vecs[i].line_oe,
                  vecs[i].rdy, vecs[i].cnt);
        end
        vecs.delete();
    endtask

    task automatic add_six_ones();
        for (int i = 1; i <= 5; i++) add(1, 1, 0, LJ, 1, 1, 3'(i));
        add(1, 1, 0, LJ, 1, ~STUFF_ON, 3'd6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        rstN = 1'b0;
        repeat (2) @(negedge useClk);
        check("reset", LJ, 1'b0, 1'b1, 3'd0);
        rstN = 1'b1;
        @(negedge useClk);

        // ACK: sync 00000001, PID 0xD2 LSB-first, callEop held three bits
        for (int i = 0; i < 7; i++) add(1, 0, 0, i[0] ? LJ : LK, 1, 1, 0);
        add(1, 1, 0, LK, 1, 1, 1);
        add(1, 0, 0, LJ, 1, 1, 0);
        add(1, 1, 0, LJ, 1, 1, 1);
        add(1, 0, 0, LK, 1, 1, 0);
        add(1, 0, 0, LJ, 1, 1, 0);
        add(1, 1, 0, LJ, 1, 1, 1);
        add(1, 0, 0, LK, 1, 1, 0);
        add(1, 1, 0, LK, 1, 1, 1);
        add(1, 1, 0, LK, 1, 1, 2);
        add(1, 0, 1, LS, 1, 1, 0);
        add(1, 0, 1, LS, 1, 1, 0);
        add(1, 0, 1, LJ, 1, 1, 0);
        add(1, 0, 0, LJ, 0, 1, 0);
        add(0, 0, 0, LJ, 0, 1, 0);
        run_table("ack");

        // Re-rising callEop during EOP_J and in IDLE is ignored
        add(1, 1, 0, LJ, 1, 1, 1);
        add(1, 0, 1, LS, 1, 1, 0);
        add(0, 0, 0, LS, 1, 1, 0);
        add(0, 0, 0, LJ, 1, 1, 0);
        add(0, 0, 1, LJ, 0, 1, 0);
        add(0, 0, 0, LJ, 0, 1, 0);
        add(0, 0, 1, LJ, 0, 1, 0);
        add(0, 0, 0, LJ, 0, 1, 0);
        run_table("eop_rerise");

        // txOE falling without EOP aborts to idle
        add(1, 1, 0, LJ, 1, 1, 1);
        add(1, 0, 0, LK, 1, 1, 0);
        add(1, 1, 0, LK, 1, 1, 1);
        add(0, 0, 0, LJ, 0, 1, 0);
        add(0, 0, 0, LJ, 0, 1, 0);
        run_table("oe_fall");

        // Seven raw ones: stuffed toggle after the sixth when stuffing is built in
        add_six_ones();
        add(1, 1, 0, STUFF_ON ? LK : LJ, 1, 1, STUFF_ON ? 3'd0 : 3'd7);
        add(1, 1, 0, STUFF_ON ? LK : LJ, 1, 1, STUFF_ON ? 3'd1 : 3'd7);
        add(1, 1, 0, STUFF_ON ? LK : LJ, 1, 1, STUFF_ON ? 3'd2 : 3'd7);
        add(0, 0, 0, LJ, 0, 1, 0);
        run_table("stuff");

        // EOP requested where the stuffed bit would go: EOP wins
        add_six_ones();
        add(1, 1, 1, LS, 1, 1, 0);
        add(1, 1, 1, LS, 1, 1, 0);
        add(1, 1, 0, LJ, 1, 1, 0);
        add(0, 0, 0, LJ, 0, 1, 0);
        run_table("stuff_eop");

        // checkData gated low for 5 clocks mid-packet: everything frozen
        drive_bit(1, 0, 0);
        check("freeze_pre0", LK, 1, 1, 0);
        drive_bit(1, 1, 0);
        check("freeze_pre1", LK, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            txOE    = i[0];
            txBit   = ~i[0];
            callEop = 1'b1;
            @(negedge useClk);
            check($sformatf("freeze[%0d]", i), LK, 1, 1, 1);
        end
        drive_bit(1, 0, 0);
        check("freeze_resume", LJ, 1, 1, 0);
        drive_bit(0, 0, 0);
        check("freeze_end", LJ, 0, 1, 0);

        // Asynchronous reset between clock edges in the middle of a packet
        drive_bit(1, 0, 0);
        check("rst_pre0", LK, 1, 1, 0);
        drive_bit(1, 1, 1);
        check("rst_pre1", LS, 1, 1, 0);
        #2 rstN = 1'b0;
        #1 check("rst_async", LJ, 0, 1, 0);
        @(negedge useClk);
        rstN = 1'b1;
        drive_bit(0, 0, 1);
        check("rst_post0", LJ, 0, 1, 0);
        drive_bit(0, 0, 0);
        check("rst_post1", LJ, 0, 1, 0);
        drive_bit(0, 0, 0);
        check("rst_post2", LJ, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
